// File: rtl/tm1638_link_scheduler.sv
// tm1638_link_scheduler
//   Shares one byte-level TM1638 SIO engine between N_REQ requesters.
//   Each grant covers a whole frame: STB low, command byte, 0..15 data
//   bytes (write or read), STB high, and a minimum STB-high gap.
//   Requesters are served round-robin.
//
// Parameters
//   N_REQ   number of requesters (2..4)
//   clk_mhz clock frequency in MHz (sets gap and watchdog lengths)
//   GAP_US  minimum STB-high time between frames, in microseconds
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req, rd           per-requester frame request / frame type (1 = read)
//   cmd, len          per-requester command byte / data byte count
//   wr_data           per-requester next write byte
//   gnt               one-hot grant, high for the whole frame and gap
//   wr_ready          granted requester's write byte consumed
//   rd_data, rd_valid last byte read and its 1-cycle strobe
//   done              1-cycle pulse in the last cycle of gnt
//   error             engine watchdog expiry pulse (optional feature)
//   sio_latch/din     byte start strobe and byte to the engine
//   sio_dout/busy     byte from the engine and engine busy flag
//   sio_stb           TM1638 STB (active-low)
//   sio_oe            DIO drive enable (1 = controller drives)
//
// Optional feature: define TM1638_LINK_TIMEOUT_EN to build a watchdog on
// the engine handshake; without it, error is tied low and waits are
// unbounded.

module tm1638_link_scheduler #(
  parameter int N_REQ   = 2,
  parameter int clk_mhz = 50,
  parameter int GAP_US  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     rd,
  input  logic [8*N_REQ-1:0]   cmd,
  input  logic [4*N_REQ-1:0]   len,
  input  logic [8*N_REQ-1:0]   wr_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 wr_ready,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 error,
  output logic                 sio_latch,
  output logic [7:0]           sio_din,
  input  logic [7:0]           sio_dout,
  input  logic                 sio_busy,
  output logic                 sio_stb,
  output logic                 sio_oe
);

  localparam int IDX_W   = (N_REQ > 2) ? 2 : 1;
  localparam int GAP_RAW = GAP_US * clk_mhz;
  localparam int GAP_CYC = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD_LATCH, CMD_WAIT, DATA_LATCH, DATA_WAIT, GAP
  } state_t;

  state_t             state, state_n;
  logic [N_REQ-1:0]   gnt_n;
  logic [IDX_W-1:0]   cur, cur_n;      // index of the granted requester
  logic [IDX_W-1:0]   ptr, ptr_n;      // last requester that finished a frame
  logic [7:0]         cmd_q, cmd_q_n;
  logic [3:0]         len_q, len_q_n;
  logic               rd_q, rd_q_n;
  logic [3:0]         byte_cnt, byte_cnt_n;
  logic               seen_busy, seen_busy_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               stb_n, oe_n, rd_valid_n;
  logic [7:0]         rd_data_n;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               in_wait, byte_done, wd_expire;

  assign in_wait   = (state == CMD_WAIT) || (state == DATA_WAIT);
  // A byte is complete once busy has been seen high and is now seen low.
  assign byte_done = in_wait && seen_busy && !sio_busy;

  // Round-robin search starting just after the last finished requester.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = ptr;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

`ifdef TM1638_LINK_TIMEOUT_EN
  localparam int RISE_LIM = 64;
  localparam int FALL_RAW = 4096 * clk_mhz;
  localparam int FALL_LIM = (FALL_RAW > 65536) ? 65536 : FALL_RAW;

  logic [15:0] wd_cnt, wd_cnt_n;

  // The watchdog restarts when busy rises, so each phase gets its own limit.
  always_comb begin
    wd_cnt_n  = '0;
    wd_expire = 1'b0;
    if (in_wait) begin
      if (!seen_busy && sio_busy) wd_cnt_n = '0;
      else                        wd_cnt_n = wd_cnt + 16'd1;
      wd_expire = (!seen_busy && !sio_busy && wd_cnt == 16'(RISE_LIM - 1)) ||
                  ( seen_busy &&  sio_busy && wd_cnt == 16'(FALL_LIM - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_cnt <= '0;
    else     wd_cnt <= wd_cnt_n;
  end

  assign error = wd_expire;
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    cur_n       = cur;
    ptr_n       = ptr;
    cmd_q_n     = cmd_q;
    len_q_n     = len_q;
    rd_q_n      = rd_q;
    byte_cnt_n  = byte_cnt;
    seen_busy_n = 1'b0;
    gap_cnt_n   = '0;
    stb_n       = sio_stb;
    oe_n        = sio_oe;
    rd_data_n   = rd_data;
    rd_valid_n  = 1'b0;
    sio_latch   = 1'b0;
    sio_din     = 8'h00;
    wr_ready    = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_n         = SETUP;
          gnt_n           = '0;
          gnt_n[win_idx]  = 1'b1;
          cur_n           = win_idx;
          cmd_q_n         = cmd[win_idx*8 +: 8];
          len_q_n         = len[win_idx*4 +: 4];
          rd_q_n          = rd[win_idx];
          byte_cnt_n      = 4'd0;
          stb_n           = 1'b0;
          oe_n            = 1'b1;
        end
      end

      SETUP: state_n = CMD_LATCH;

      CMD_LATCH: begin
        sio_latch = 1'b1;
        sio_din   = cmd_q;
        state_n   = CMD_WAIT;
      end

      CMD_WAIT: begin
        seen_busy_n = seen_busy | sio_busy;
        if (byte_done) begin
          if (len_q == 4'd0) begin
            state_n = GAP;
            stb_n   = 1'b1;
            oe_n    = 1'b1;
          end else begin
            state_n = DATA_LATCH;
            // Release DIO before the first read byte is clocked in.
            if (rd_q) oe_n = 1'b0;
          end
        end else if (wd_expire) begin
          state_n = GAP;
          stb_n   = 1'b1;
          oe_n    = 1'b1;
        end
      end

      DATA_LATCH: begin
        sio_latch = 1'b1;
        state_n   = DATA_WAIT;
        if (!rd_q) begin
          sio_din  = wr_data[cur*8 +: 8];
          wr_ready = 1'b1;
        end
      end

      DATA_WAIT: begin
        seen_busy_n = seen_busy | sio_busy;
        if (byte_done) begin
          byte_cnt_n = byte_cnt + 4'd1;
          if (rd_q) begin
            rd_data_n  = sio_dout;
            rd_valid_n = 1'b1;
          end
          if (byte_cnt_n == len_q) begin
            state_n = GAP;
            stb_n   = 1'b1;
            oe_n    = 1'b1;
          end else begin
            state_n = DATA_LATCH;
          end
        end else if (wd_expire) begin
          state_n = GAP;
          stb_n   = 1'b1;
          oe_n    = 1'b1;
        end
      end

      GAP: begin
        gap_cnt_n = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          done    = 1'b1;
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = cur;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      cur       <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
      cmd_q     <= 8'h00;
      len_q     <= 4'd0;
      rd_q      <= 1'b0;
      byte_cnt  <= 4'd0;
      seen_busy <= 1'b0;
      gap_cnt   <= '0;
      sio_stb   <= 1'b1;
      sio_oe    <= 1'b1;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      cur       <= cur_n;
      ptr       <= ptr_n;
      cmd_q     <= cmd_q_n;
      len_q     <= len_q_n;
      rd_q      <= rd_q_n;
      byte_cnt  <= byte_cnt_n;
      seen_busy <= seen_busy_n;
      gap_cnt   <= gap_cnt_n;
      sio_stb   <= stb_n;
      sio_oe    <= oe_n;
      rd_data   <= rd_data_n;
      rd_valid  <= rd_valid_n;
    end
  end

endmodule

// File: tb/tb_tm1638_link_scheduler.sv
// Directed testbench for tm1638_link_scheduler (N_REQ=2, clk_mhz=4,
// GAP_US=1 -> 4-cycle gap). The engine model raises busy one cycle after
// each latch and holds it for 10 cycles; within a frame the n-th latch
// returns 0xA0+n on sio_dout.

module tb_tm1638_link_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, rd;
  logic [15:0] cmd;
  logic [7:0]  len;
  logic [7:0]  wr1;
  logic [15:0] wr_data;
  logic [1:0]  gnt;
  logic        wr_ready, rd_valid, done, error, sio_latch, sio_busy, sio_stb, sio_oe;
  logic [7:0]  rd_data, sio_din, sio_dout;

  tm1638_link_scheduler #(.N_REQ(2), .clk_mhz(4), .GAP_US(1)) dut (
    .clk(clk), .rst(rst), .req(req), .rd(rd), .cmd(cmd), .len(len),
    .wr_data(wr_data), .gnt(gnt), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .error(error), .sio_latch(sio_latch),
    .sio_din(sio_din), .sio_dout(sio_dout), .sio_busy(sio_busy),
    .sio_stb(sio_stb), .sio_oe(sio_oe)
  );

  always #5 clk = ~clk;

  // Engine model and requester-0 write byte source (0x11, 0x22, 0x33, ...).
  logic [3:0] busy_cnt;
  logic [7:0] frame_lat;
  logic [1:0] wr_idx;
  logic       engine_dead;

  assign sio_busy = (busy_cnt != 4'd0);
  assign wr_data  = {wr1, 8'(8'h11 * (8'(wr_idx) + 8'd1))};

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt  <= 4'd0;
      frame_lat <= 8'd0;
      sio_dout  <= 8'h00;
      wr_idx    <= 2'd0;
    end else begin
      if (sio_latch && !engine_dead) busy_cnt <= 4'd10;
      else if (busy_cnt != 4'd0)     busy_cnt <= busy_cnt - 4'd1;
      if (sio_stb) frame_lat <= 8'd0;
      else if (sio_latch) begin
        frame_lat <= frame_lat + 8'd1;
        sio_dout  <= 8'hA0 + frame_lat;
      end
      if (done)          wr_idx <= 2'd0;
      else if (wr_ready) wr_idx <= wr_idx + 2'd1;
    end
  end

  int n_cmp, n_bad;

  // Per-cycle observation, sampled on the falling edge.
  logic [7:0] din_log[$];
  logic [7:0] rd_log[$];
  logic [1:0] grant_log[$];
  int         idle_log[$];
  int n_wr, n_rdv, n_done, n_err, n_gnt01, n_gnt10, stb_low, gap_cyc;
  int oe_low, oe_low_gap, idle_run, cyc, first_latch_cyc, err_cyc, done_cyc;
  logic [1:0] prev_gnt;
  logic       saw_done;

  task automatic clear_mon();
    din_log.delete(); rd_log.delete(); grant_log.delete(); idle_log.delete();
    n_wr = 0; n_rdv = 0; n_done = 0; n_err = 0; n_gnt01 = 0; n_gnt10 = 0;
    stb_low = 0; gap_cyc = 0; oe_low = 0; oe_low_gap = 0; idle_run = 0;
    first_latch_cyc = -1; err_cyc = -1; done_cyc = -1; prev_gnt = gnt;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    saw_done = done;
    if (sio_latch) begin
      din_log.push_back(sio_din);
      if (first_latch_cyc < 0) first_latch_cyc = cyc;
    end
    if (wr_ready) n_wr++;
    if (rd_valid) begin rd_log.push_back(rd_data); n_rdv++; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (error) begin n_err++; err_cyc = cyc; end
    if (gnt == 2'b01) n_gnt01++;
    if (gnt == 2'b10) n_gnt10++;
    if (gnt != 2'b00) begin
      if (sio_stb) gap_cyc++; else stb_low++;
      if (!sio_oe) begin oe_low++; if (sio_stb) oe_low_gap++; end
    end
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      grant_log.push_back(gnt);
      idle_log.push_back(idle_run);
    end
    if (gnt == 2'b00) idle_run++; else idle_run = 0;
    prev_gnt = gnt;
  endtask

  task automatic wait_done(input int budget, input string name);
    n_cmp++;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (saw_done) return;
    end
    n_bad++;
    $display("FAIL %s: done not seen within %0d cycles", name, budget);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== 2'b00)     begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0)    begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if (sio_latch !== 1'b0) begin n_bad++; $display("FAIL reset_latch: got %b want 0", sio_latch); end
    n_cmp++; if (sio_din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %h want 00", sio_din); end
    n_cmp++; if (sio_stb !== 1'b1)  begin n_bad++; $display("FAIL reset_stb: got %b want 1", sio_stb); end
    n_cmp++; if (sio_oe !== 1'b1)   begin n_bad++; $display("FAIL reset_oe: got %b want 1", sio_oe); end
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (gnt !== 2'b00 || sio_stb !== 1'b1) begin
      n_bad++; $display("FAIL idle_no_req: gnt %b stb %b want 00/1", gnt, sio_stb);
    end
  endtask

  task automatic test_write_frame();
    logic [7:0] exp_din [4];
    logic [7:0] got;
    exp_din = '{8'hC0, 8'h11, 8'h22, 8'h33};
    clear_mon();
    req = 2'b01; rd = 2'b00; cmd = 16'h00C0; len = 8'h03;
    wait_done(200, "write_done");
    req = 2'b00;
    tick(); tick();
    n_cmp++; if (din_log.size() != 4) begin n_bad++; $display("FAIL write_latches: got %0d want 4", din_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < din_log.size()) ? din_log[i] : 8'hxx;
      n_cmp++; if (got !== exp_din[i]) begin n_bad++; $display("FAIL write_din[%0d]: got %h want %h", i, got, exp_din[i]); end
    end
    n_cmp++; if (n_wr != 3)      begin n_bad++; $display("FAIL write_wr_ready: got %0d want 3", n_wr); end
    n_cmp++; if (stb_low != 49)  begin n_bad++; $display("FAIL write_stb_low: got %0d want 49", stb_low); end
    n_cmp++; if (gap_cyc != 4)   begin n_bad++; $display("FAIL write_gap: got %0d want 4", gap_cyc); end
    n_cmp++; if (n_done != 1)    begin n_bad++; $display("FAIL write_done_cnt: got %0d want 1", n_done); end
    n_cmp++; if (n_gnt01 != 53 || n_gnt10 != 0) begin
      n_bad++; $display("FAIL write_gnt: gnt01 %0d gnt10 %0d want 53/0", n_gnt01, n_gnt10);
    end
    n_cmp++; if (gnt !== 2'b00)  begin n_bad++; $display("FAIL write_gnt_clear: got %b want 00", gnt); end
  endtask

  task automatic test_read_frame();
    logic [7:0] exp_din [5];
    logic [7:0] exp_rd [4];
    logic [7:0] got;
    exp_din = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_rd  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    clear_mon();
    req = 2'b10; rd = 2'b10; cmd = 16'h4200; len = 8'h40;
    wait_done(200, "read_done");
    req = 2'b00; rd = 2'b00;
    tick(); tick();
    n_cmp++; if (din_log.size() != 5) begin n_bad++; $display("FAIL read_latches: got %0d want 5", din_log.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < din_log.size()) ? din_log[i] : 8'hxx;
      n_cmp++; if (got !== exp_din[i]) begin n_bad++; $display("FAIL read_din[%0d]: got %h want %h", i, got, exp_din[i]); end
    end
    n_cmp++; if (rd_log.size() != 4) begin n_bad++; $display("FAIL read_rd_valid: got %0d want 4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
      n_cmp++; if (got !== exp_rd[i]) begin n_bad++; $display("FAIL read_data[%0d]: got %h want %h", i, got, exp_rd[i]); end
    end
    n_cmp++; if (n_wr != 0)       begin n_bad++; $display("FAIL read_wr_ready: got %0d want 0", n_wr); end
    n_cmp++; if (oe_low != 48)    begin n_bad++; $display("FAIL read_oe_low: got %0d want 48", oe_low); end
    n_cmp++; if (oe_low_gap != 0) begin n_bad++; $display("FAIL read_oe_gap: got %0d want 0", oe_low_gap); end
    n_cmp++; if (rd_data !== 8'hA4) begin n_bad++; $display("FAIL read_hold: got %h want a4", rd_data); end
    n_cmp++; if (n_gnt10 != 65 || n_gnt01 != 0) begin
      n_bad++; $display("FAIL read_gnt: gnt10 %0d gnt01 %0d want 65/0", n_gnt10, n_gnt01);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    logic [7:0] exp_din [4];
    logic [1:0] g;
    logic [7:0] got;
    exp_g   = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_din = '{8'h80, 8'h81, 8'h80, 8'h81};
    clear_mon();
    req = 2'b11; rd = 2'b00; cmd = 16'h8180; len = 8'h00;
    for (int f = 0; f < 4; f++) wait_done(60, "contention_done");
    req = 2'b00;
    tick(); tick();
    n_cmp++; if (grant_log.size() != 4) begin n_bad++; $display("FAIL cont_grants: got %0d want 4", grant_log.size()); end
    for (int i = 0; i < 4; i++) begin
      g   = (i < grant_log.size()) ? grant_log[i] : 2'bxx;
      got = (i < din_log.size()) ? din_log[i] : 8'hxx;
      n_cmp++; if (g !== exp_g[i])     begin n_bad++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, g, exp_g[i]); end
      n_cmp++; if (got !== exp_din[i]) begin n_bad++; $display("FAIL cont_din[%0d]: got %h want %h", i, got, exp_din[i]); end
      if (i > 0) begin
        n_cmp++; if (i >= idle_log.size() || idle_log[i] != 1) begin
          n_bad++; $display("FAIL cont_idle[%0d]: gnt-low cycles between frames not 1", i);
        end
      end
    end
    n_cmp++; if (n_done != 4 || n_wr != 0 || n_rdv != 0) begin
      n_bad++; $display("FAIL cont_pulses: done %0d wr %0d rdv %0d want 4/0/0", n_done, n_wr, n_rdv);
    end
  endtask

  task automatic test_cmd_only();
    clear_mon();
    req = 2'b01; rd = 2'b01; cmd = 16'h0090; len = 8'h00;
    tick();
    // Mid-frame changes must be ignored in favour of the captured values.
    cmd = 16'h00FF; len = 8'h0F; rd = 2'b00;
    wait_done(60, "cmd_only_done");
    req = 2'b00;
    tick(); tick();
    n_cmp++; if (din_log.size() != 1) begin n_bad++; $display("FAIL cmd_only_latches: got %0d want 1", din_log.size()); end
    n_cmp++; if (din_log.size() < 1 || din_log[0] !== 8'h90) begin n_bad++; $display("FAIL cmd_only_din: first latch byte not 90"); end
    n_cmp++; if (n_wr != 0 || n_rdv != 0) begin n_bad++; $display("FAIL cmd_only_pulses: wr %0d rdv %0d want 0/0", n_wr, n_rdv); end
    n_cmp++; if (oe_low != 0)  begin n_bad++; $display("FAIL cmd_only_oe: got %0d want 0", oe_low); end
    n_cmp++; if (n_done != 1)  begin n_bad++; $display("FAIL cmd_only_done_cnt: got %0d want 1", n_done); end
    n_cmp++; if (stb_low != 13 || gap_cyc != 4) begin
      n_bad++; $display("FAIL cmd_only_stb: low %0d gap %0d want 13/4", stb_low, gap_cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    clear_mon();
    req = 2'b10; rd = 2'b10; cmd = 16'h4200; len = 8'h40;
    k = 0;
    while (din_log.size() < 3 && k < 100) begin tick(); k++; end
    n_cmp++; if (din_log.size() < 3) begin n_bad++; $display("FAIL midrst_reach: latches %0d want 3", din_log.size()); end
    tick(); tick();
    rst = 1'b1; req = 2'b11; rd = 2'b00; cmd = 16'h42B5; len = 8'h40;
    tick();
    n_cmp++; if (sio_stb !== 1'b1)   begin n_bad++; $display("FAIL midrst_stb: got %b want 1", sio_stb); end
    n_cmp++; if (sio_oe !== 1'b1)    begin n_bad++; $display("FAIL midrst_oe: got %b want 1", sio_oe); end
    n_cmp++; if (gnt !== 2'b00)      begin n_bad++; $display("FAIL midrst_gnt: got %b want 00", gnt); end
    n_cmp++; if (rd_data !== 8'h00)  begin n_bad++; $display("FAIL midrst_rd_data: got %h want 00", rd_data); end
    n_cmp++; if (sio_latch !== 1'b0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_strobes: latch %b rd_valid %b want 0/0", sio_latch, rd_valid);
    end
    rst = 1'b0;
    k = 0;
    while (gnt == 2'b00 && k < 10) begin tick(); k++; end
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL midrst_first_gnt: got %b want 01", gnt); end
    req = 2'b00;
    wait_done(60, "midrst_done");
    tick(); tick();
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL midrst_done_cnt: got %0d want 1", n_done); end
  endtask

`ifdef TM1638_LINK_TIMEOUT_EN
  task automatic test_timeout();
    engine_dead = 1'b1;
    clear_mon();
    req = 2'b01; rd = 2'b00; cmd = 16'h00C1; len = 8'h01;
    wait_done(200, "timeout_done");
    req = 2'b00; engine_dead = 1'b0;
    tick();
    n_cmp++; if (n_err != 1) begin n_bad++; $display("FAIL timeout_err_cnt: got %0d want 1", n_err); end
    n_cmp++; if (err_cyc - first_latch_cyc != 64) begin
      n_bad++; $display("FAIL timeout_delay: got %0d want 64", err_cyc - first_latch_cyc);
    end
    n_cmp++; if (done_cyc - err_cyc != 4) begin n_bad++; $display("FAIL timeout_gap: got %0d want 4", done_cyc - err_cyc); end
    n_cmp++; if (n_wr != 0 || din_log.size() != 1) begin
      n_bad++; $display("FAIL timeout_abort: wr %0d latches %0d want 0/1", n_wr, din_log.size());
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; req = 2'b00; rd = 2'b00; cmd = 16'h0000; len = 8'h00;
    wr1 = 8'h5A; engine_dead = 1'b0; prev_gnt = 2'b00; saw_done = 1'b0;
    test_reset();
    test_write_frame();
    test_read_frame();
    test_contention();
    test_cmd_only();
    test_reset_mid_frame();
`ifdef TM1638_LINK_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tm1638_link_scheduler.md
Name: tm1638_link_scheduler

Overview:
- Shares one byte-level TM1638 SIO engine between N_REQ requesters, for example a display refresher, a key scanner and a host debug port.
- Arbitrates whole frames. One frame is: STB low, command byte, 0..15 write or read bytes, STB high, then a minimum STB-high gap.
- Sequences the engine's latch/busy handshake and drives the STB and DIO direction lines.
- Sits between the board-level requesters and the tm1638 SIO shifter.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- clk_mhz, 50, clock frequency in MHz; sets the gap length.
- GAP_US, 1, minimum STB-high time between frames, in microseconds.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req  in  N_REQ  frame request per requester. Held until that requester's done.
- rd  in  N_REQ  per-requester frame type: 1 = read frame, 0 = write frame.
- cmd  in  8*N_REQ  command byte per requester; slice i is bits [8i+7:8i].
- len  in  4*N_REQ  number of data bytes after the command, per requester.
- wr_data  in  8*N_REQ  next write byte per requester.
- gnt  out  N_REQ  one-hot grant, high for the whole frame including the gap.
- wr_ready  out  1  1-cycle pulse: granted requester's wr_data consumed; present the next byte.
- rd_data  out  8  last byte read.
- rd_valid  out  1  1-cycle pulse: rd_data valid.
- done  out  1  1-cycle pulse at the end of a frame, coincident with the last cycle of gnt.
- error  out  1  1-cycle pulse on engine timeout (optional feature only).
- sio_latch  out  1  engine byte start, 1 cycle.
- sio_din  out  8  byte to the engine.
- sio_dout  in  8  byte from the engine.
- sio_busy  in  1  engine busy.
- sio_stb  out  1  TM1638 STB line, active-low.
- sio_oe  out  1  DIO drive enable (1 = controller drives).

Behaviour:
- Reset values: gnt=0, wr_ready=0, rd_data=0x00, rd_valid=0, done=0, error=0, sio_latch=0, sio_din=0x00, sio_stb=1, sio_oe=1.
- Reset mid-frame: outputs take their reset values at the next edge; the FSM goes to IDLE; the arbitration pointer resets to N_REQ-1, so requester 0 has top priority first.
- States: IDLE, SETUP, CMD_LATCH, CMD_WAIT, DATA_LATCH, DATA_WAIT, GAP.
- IDLE: when req != 0, pick the winner by round-robin, searching from (last+1) mod N_REQ upward. Next edge: gnt[winner]=1, sio_stb=0, sio_oe=1, go to SETUP. The winner's cmd, len and rd are captured at this edge and held for the frame.
- SETUP: one cycle of STB setup, then CMD_LATCH.
- CMD_LATCH: sio_latch=1 and sio_din=cmd for exactly one cycle, then CMD_WAIT.
- Byte completion (both wait states): wait until sio_busy has been seen high, then until it is seen low. The cycle busy is seen low is "byte complete".
- CMD_WAIT, byte complete:
  - len=0: go to GAP.
  - otherwise: go to DATA_LATCH; if rd=1, sio_oe=0 at the same edge.
- DATA_LATCH, write frame: sio_din=wr_data[gnt], sio_latch=1, and wr_ready pulses in this same cycle.
- DATA_LATCH, read frame: sio_din=0x00, sio_latch=1, no wr_ready.
- DATA_WAIT, byte complete:
  - Read frame: rd_data=sio_dout and rd_valid pulses on the following cycle.
  - Byte counter increments.
  - Counter == len: go to GAP. Otherwise: go to DATA_LATCH.
- Minimum spacing between latches is 2 cycles.
- GAP: sio_stb=1 and sio_oe=1 on entry. Count GAP_US*clk_mhz cycles; a value of 0 is clamped to 1. Then done pulses, gnt clears at the following edge, and the FSM returns to IDLE. The pointer is updated to the finished requester.
- A requester cannot be re-granted in the same cycle done pulses. The earliest new frame is 1 cycle after done.
- req deasserted mid-frame is ignored; the frame completes in full.
- Changes to cmd/len/rd mid-frame are ignored (captured values are used).
- The byte counter is 4 bits; len=15 gives 15 data bytes, with no wrap.
- sio_busy high while in IDLE is ignored.

Optional Feature:
- Macro: TM1638_LINK_TIMEOUT_EN.
- With it: in each wait state, a 16-bit watchdog counts cycles. The limit is 64 cycles waiting for busy to rise, and 4096*clk_mhz cycles waiting for it to fall. On expiry: error pulses, the frame aborts via GAP, done pulses normally, and no further wr_ready or rd_valid is issued.
- Without it: error is tied to 0, waits are unbounded, and no watchdog logic is built.

Test Plan:
- Setup for all cases: clk_mhz=4, GAP_US=1 (4-cycle gap), engine model busy for 10 cycles starting 1 cycle after latch.
- Write frame: req0, rd=0, cmd=0xC0, len=3, bytes 0x11/0x22/0x33 → sio_din sequence 0xC0, 0x11, 0x22, 0x33; 3 wr_ready pulses; stb low for the whole transfer; 4-cycle stb-high gap; one done pulse; gnt=01 throughout.
- Read frame: req1, rd=1, cmd=0x42, len=4, engine returns 0xA1..0xA4 → sio_oe falls after the command byte completes; 4 rd_valid pulses with rd_data 0xA1..0xA4; sio_oe=1 again in GAP.
- Contention: req0 and req1 both held continuously, len=0 → grants alternate 0, 1, 0, 1; each done followed by the next gnt 1 cycle later.
- Command-only frame with len=0 → exactly one sio_latch; no wr_ready or rd_valid; done pulses.
- Reset asserted 2 cycles into the second data byte → next edge: sio_stb=1, sio_oe=1, gnt=0. After release, req1 and req0 both pending → req0 is granted.
- With TM1638_LINK_TIMEOUT_EN: engine never raises busy → error pulses 64 cycles after latch, then done follows after the gap.
